uart_rx_fifo: RTL and testbench

//  Parametrised UART receiver with majority-vote sampling, optional parity, error/break detection
//  and a show-ahead receive FIFO. Replaces the bare byte receiver behind enigma_top's command parser.
//  It decouples host bursts (e.g. ":?" command streams) from parser latency.

---
 rtl/uart_rx_fifo_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/uart_rx_fifo.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receiver: parity modes, FSM states, board default timing.
package uart_rx_fifo_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  // 12 MHz / 115200 baud
  localparam int unsigned CLKS_PER_BIT_12MHZ = 104;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StStop2,
    StWaitHi
  } rx_state_e;

  // 2-of-3 vote used for every bit decision
  function automatic logic majority3(logic a, logic b, logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with simultaneous push/pop and an explicit occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] CountFull = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CountFull);
  assign count   = count_q;
  // Zero while empty so the head port reads 0 out of reset
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // Accept/advance decisions; a pop frees a slot for a same-cycle push even when full
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  // Pointer and count state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since reads are masked while empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with 2-of-3 mid-bit voting, optional parity, frame/break detection and an RX FIFO.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_12MHZ,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = PARITY_NONE,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic                          break_det
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntSmp0 = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] CntSmp1 = CntW'(CLKS_PER_BIT / 2);
  localparam logic [CntW-1:0] CntDec  = CntW'(CLKS_PER_BIT / 2 + 1);
  localparam logic [CntW-1:0] CntEnd  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      BitLast = 3'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           smp_q, smp_d;
  logic [1:0]           sync_vld_q, sync_vld_d;
  logic                 rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
  logic                 armed_q, armed_d;
  logic                 par_bad_q, par_bad_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;
  logic                 break_q, break_d;
  logic                 push, fifo_full, fifo_empty, maj, decide, exp_par;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shift_q),
    .pop       (rd_en),
    .rd_data   (rd_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rd_valid   = !fifo_empty;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign break_det  = break_q;

  assign maj     = majority3(smp_q[0], smp_q[1], rx_sync_q);
  assign decide  = (cnt_q == CntDec);
  assign exp_par = (PARITY == PARITY_EVEN) ? ^shift_q : ~^shift_q;

  // Receiver next-state: synchroniser, bit timer, voter and frame FSM
  always_comb begin
    rx_meta_d    = rx;
    rx_sync_d    = rx_meta_q;
    sync_vld_d   = {sync_vld_q[0], 1'b1};
    // Only arm once a genuine high has reached the synchroniser output
    armed_d      = armed_q | (sync_vld_q[1] & rx_sync_q);
    state_d      = state_q;
    cnt_d        = (cnt_q == CntEnd) ? '0 : cnt_q + 1'b1;
    bit_d        = bit_q;
    shift_d      = shift_q;
    smp_d        = smp_q;
    par_bad_d    = par_bad_q;
    break_d      = break_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    push         = 1'b0;

    if (cnt_q == CntSmp0) smp_d[0] = rx_sync_q;
    if (cnt_q == CntSmp1) smp_d[1] = rx_sync_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (armed_q && !rx_sync_q) begin
          state_d = StStart;
          // The detecting cycle is count 0 of the start bit
          cnt_d   = CntW'(1);
        end
      end
      StStart: begin
        if (decide && maj) begin
          state_d = StIdle;
        end else if (cnt_q == CntEnd) begin
          state_d   = StData;
          bit_d     = '0;
          par_bad_d = 1'b0;
        end
      end
      StData: begin
        if (decide) shift_d = {maj, shift_q[DATA_BITS-1:1]};
        if (cnt_q == CntEnd) begin
          if (bit_q == BitLast) state_d = (PARITY != PARITY_NONE) ? StParity : StStop;
          else                  bit_d   = bit_q + 1'b1;
        end
      end
      StParity: begin
        if (decide) par_bad_d = (maj != exp_par);
        if (cnt_q == CntEnd) state_d = StStop;
      end
      StStop: begin
        if (decide) begin
          if (maj) begin
            push         = 1'b1;
            parity_err_d = par_bad_q;
            state_d      = (STOP_BITS == 2) ? StStop2 : StIdle;
          end else begin
            frame_err_d = 1'b1;
            if (shift_q == '0 && !par_bad_q) break_d = 1'b1;
            state_d = StWaitHi;
          end
        end
      end
      StStop2: begin
        if (cnt_q == CntEnd) state_d = StIdle;
      end
      StWaitHi: begin
        if (rx_sync_q) begin
          break_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q && state_q != StIdle) cnt_d = '0;

    overrun_d = push && fifo_full && !rd_en;
  end

  // Receiver state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      sync_vld_q   <= '0;
      armed_q      <= 1'b0;
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      smp_q        <= '0;
      par_bad_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      break_q      <= 1'b0;
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
      sync_vld_q   <= sync_vld_d;
      armed_q      <= armed_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      smp_q        <= smp_d;
      par_bad_q    <= par_bad_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      break_q      <= break_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, directed corner sequences, random model check.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int CPB = 104;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1, rx_p = 1'b1;
  logic       rd_en = 1'b0, rd_en_p = 1'b0;
  logic [7:0] rd_data, rd_data_e, rd_data_o;
  logic       rd_valid, rd_valid_e, rd_valid_o;
  logic [4:0] cnt, cnt_e, cnt_o;
  logic       ferr, perr, ovr, brk;
  logic       ferr_e, perr_e, ovr_e, brk_e;
  logic       ferr_o, perr_o, ovr_o, brk_o;

  always #41.667 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                 .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_count(cnt), .frame_err(ferr), .parity_err(perr), .overrun(ovr), .break_det(brk));

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
                 .FIFO_DEPTH(16)) dut_e (
    .clk(clk), .rst_n(rst_n), .rx(rx_p), .rd_en(rd_en_p), .rd_data(rd_data_e),
    .rd_valid(rd_valid_e), .fifo_count(cnt_e), .frame_err(ferr_e), .parity_err(perr_e),
    .overrun(ovr_e), .break_det(brk_e));

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
                 .FIFO_DEPTH(16)) dut_o (
    .clk(clk), .rst_n(rst_n), .rx(rx_p), .rd_en(rd_en_p), .rd_data(rd_data_o),
    .rd_valid(rd_valid_o), .fifo_count(cnt_o), .frame_err(ferr_o), .parity_err(perr_o),
    .overrun(ovr_o), .break_det(brk_o));

  // Pulse monitors: monotonic event counters, sampled on the falling edge
  int cyc = 0, rise_cyc = 0, stop_cyc = 0;
  int ferr_n = 0, perr_n = 0, ovr_n = 0, wide_n = 0;
  int perr_e_n = 0, perr_o_n = 0, ferr_p_n = 0;
  logic ferr_q = 0, perr_q = 0, ovr_q = 0, vld_q = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ferr) ferr_n++;
    if (perr) perr_n++;
    if (ovr) ovr_n++;
    if ((ferr && ferr_q) || (perr && perr_q) || (ovr && ovr_q)) wide_n++;
    if (perr_e) perr_e_n++;
    if (perr_o) perr_o_n++;
    if (ferr_e || ferr_o) ferr_p_n++;
    if (rd_valid && !vld_q) rise_cyc = cyc;
    ferr_q = ferr; perr_q = perr; ovr_q = ovr; vld_q = rd_valid;
  end

  int n_cmp = 0, n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) rx_p = v;
    else     rx   = v;
  endtask

  // Bit-accurate 8-bit frame, optional parity bit, injectable stop value, 8-clk idle gap
  task automatic send_frame(input bit sel, input logic [7:0] data, input bit par_en,
                            input logic par_bit, input logic stop_bit);
    set_line(sel, 1'b0);
    wait_clk(CPB);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, data[i]);
      wait_clk(CPB);
    end
    if (par_en) begin
      set_line(sel, par_bit);
      wait_clk(CPB);
    end
    set_line(sel, stop_bit);
    stop_cyc = cyc;
    wait_clk(CPB);
    set_line(sel, 1'b1);
    wait_clk(8);
  endtask

  task automatic pop_main();
    rd_en = 1'b1;
    wait_clk(1);
    rd_en = 1'b0;
  endtask

  task automatic pop_par();
    rd_en_p = 1'b1;
    wait_clk(1);
    rd_en_p = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_cnt;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];
  logic [7:0] q[$];
  int s_ferr, s_perr, s_ovr, s_pe, s_po, s_fp, k;
  logic [7:0] rdat;
  bit bad;

  initial begin
    vecs[0] = '{8'h55, 1'b0, 0, 1};
    vecs[1] = '{8'h41, 1'b1, 1, 0};
    vecs[2] = '{8'h00, 1'b1, 1, 0};
    vecs[3] = '{8'hFF, 1'b1, 1, 0};
    vecs[4] = '{8'h80, 1'b1, 1, 0};
    vecs[5] = '{8'hC3, 1'b0, 0, 1};

    wait_clk(3);
    check("reset rd_valid", int'(rd_valid), 0);
    check("reset count", int'(cnt), 0);
    check("reset rd_data", int'(rd_data), 0);
    check("reset pulses", int'({ferr, perr, ovr}), 0);
    check("reset break", int'(brk), 0);
    rst_n = 1'b1;
    wait_clk(10);

    // 8N1 0x3A and push latency from the stop-bit edge
    s_ferr = ferr_n; s_perr = perr_n; s_ovr = ovr_n;
    send_frame(0, 8'h3A, 0, 1'b0, 1'b1);
    check("3A latency ok", int'((rise_cyc - stop_cyc) <= 56 && rise_cyc > stop_cyc), 1);
    check("3A data", int'(rd_data), 8'h3A);
    check("3A count", int'(cnt), 1);
    check("3A no pulses", (ferr_n - s_ferr) + (perr_n - s_perr) + (ovr_n - s_ovr), 0);
    pop_main();
    check("3A popped count", int'(cnt), 0);

    // Vector table
    for (int i = 0; i < 6; i++) begin
      s_ferr = ferr_n; s_perr = perr_n;
      send_frame(0, vecs[i].data, 0, 1'b0, vecs[i].stop);
      check($sformatf("vec%0d count", i), int'(cnt), vecs[i].exp_cnt);
      check($sformatf("vec%0d frame_err", i), ferr_n - s_ferr, vecs[i].exp_ferr);
      check($sformatf("vec%0d parity_err", i), perr_n - s_perr, 0);
      if (vecs[i].exp_cnt == 1) begin
        check($sformatf("vec%0d data", i), int'(rd_data), int'(vecs[i].data));
        pop_main();
      end
    end
    check("table break clear", int'(brk), 0);

    // Start-bit glitch, then a good frame
    s_ferr = ferr_n;
    rx = 1'b0; wait_clk(20);
    rx = 1'b1; wait_clk(200);
    check("glitch no push", int'(cnt), 0);
    check("glitch no ferr", ferr_n - s_ferr, 0);
    send_frame(0, 8'h3F, 0, 1'b0, 1'b1);
    check("post-glitch data", int'(rd_data), 8'h3F);
    check("post-glitch count", int'(cnt), 1);
    pop_main();

    // Overflow: 17 frames with no reads
    s_ovr = ovr_n;
    for (int i = 0; i < 17; i++) send_frame(0, 8'(i), 0, 1'b0, 1'b1);
    check("full count", int'(cnt), 16);
    check("overrun once", ovr_n - s_ovr, 1);
    check("full head", int'(rd_data), 8'h00);
    // Push and pop in the same cycle while full
    s_ovr = ovr_n;
    fork
      send_frame(0, 8'h77, 0, 1'b0, 1'b1);
      begin
        repeat (991) @(posedge clk);
        #1;
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
      end
    join
    check("push+pop full count", int'(cnt), 16);
    check("push+pop no overrun", ovr_n - s_ovr, 0);
    for (int i = 1; i < 17; i++) begin
      check($sformatf("drain %0d", i), int'(rd_data), (i == 16) ? 8'h77 : i);
      pop_main();
    end
    check("drained", int'(rd_valid), 0);

    // Parity: 0x3F has even ones -> even bit 0, odd bit 1
    s_pe = perr_e_n; s_po = perr_o_n; s_fp = ferr_p_n;
    send_frame(1, 8'h3F, 1, 1'b1, 1'b1);
    check("par1 even err", perr_e_n - s_pe, 1);
    check("par1 odd ok", perr_o_n - s_po, 0);
    check("par1 even data", int'(rd_data_e), 8'h3F);
    check("par1 odd data", int'(rd_data_o), 8'h3F);
    pop_par();
    s_pe = perr_e_n; s_po = perr_o_n;
    send_frame(1, 8'h3F, 1, 1'b0, 1'b1);
    check("par0 even ok", perr_e_n - s_pe, 0);
    check("par0 odd err", perr_o_n - s_po, 1);
    check("par counts", int'(cnt_e) * 32 + int'(cnt_o), 1 * 32 + 1);
    check("par no ferr", ferr_p_n - s_fp, 0);
    pop_par();

    // Break: 12 bit times low
    s_ferr = ferr_n;
    rx = 1'b0; wait_clk(12 * CPB);
    check("break level", int'(brk), 1);
    check("break ferr", ferr_n - s_ferr, 1);
    check("break no push", int'(cnt), 0);
    rx = 1'b1; wait_clk(6);
    check("break cleared", int'(brk), 0);
    wait_clk(20);

    // Reset mid-frame, released while rx is still low
    send_frame(0, 8'h11, 0, 1'b0, 1'b1);
    check("pre-reset count", int'(cnt), 1);
    rx = 1'b0; wait_clk(300);
    rst_n = 1'b0; wait_clk(2);
    check("mid reset count", int'(cnt), 0);
    check("mid reset outputs", int'({rd_valid, ferr, perr, ovr, brk}), 0);
    rst_n = 1'b1; wait_clk(250);
    rx = 1'b1; wait_clk(20);
    check("low release no push", int'(cnt), 0);
    s_ferr = ferr_n;
    send_frame(0, 8'h5A, 0, 1'b0, 1'b1);
    check("after reset count", int'(cnt), 1);
    check("after reset data", int'(rd_data), 8'h5A);
    check("after reset no ferr", ferr_n - s_ferr, 0);
    pop_main();

    // Random frames and reads against a queue model
    for (int i = 0; i < 16; i++) begin
      rdat = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 7) == 0);
      s_ferr = ferr_n; s_ovr = ovr_n;
      send_frame(0, rdat, 0, 1'b0, !bad);
      if (!bad && q.size() < 16) q.push_back(rdat);
      check($sformatf("rnd%0d ferr", i), ferr_n - s_ferr, bad ? 1 : 0);
      check($sformatf("rnd%0d ovr", i), ovr_n - s_ovr, (!bad && q.size() == 16 &&
            (ovr_n - s_ovr) == 1) ? 1 : 0);
      check($sformatf("rnd%0d count", i), int'(cnt), q.size());
      k = $urandom_range(0, 2);
      for (int j = 0; j < k; j++) begin
        if (q.size() > 0) begin
          check($sformatf("rnd%0d head", i), int'(rd_data), int'(q[0]));
          void'(q.pop_front());
        end
        pop_main();
        check($sformatf("rnd%0d pop count", i), int'(cnt), q.size());
      end
    end

    check("pulse widths", wide_n, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
